// File: rtl/mwc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mwc_pkg : state and fail-code constants shared by mem_write_checker        |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
package mwc_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ARMED = 2'd1;
  localparam state_t ST_PASS  = 2'd2;
  localparam state_t ST_FAIL  = 2'd3;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_UNEXP   = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;
  localparam logic [1:0] FC_CFG     = 2'd3;

  // Keeps single-entry tables from producing zero-width index ports.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mwc_exp_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mwc_exp_table : expected-write table, one write port, one async read port  |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module mwc_exp_table
  import mwc_pkg::*;
#(
  parameter int NUM_EXP = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 3,
  parameter int PTR_W   = 4
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [IDX_W-1:0]  wrIdx,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [PTR_W-1:0]  rdIdx,
  output logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [ADDR_W-1:0] r_addrMem [NUM_EXP];
  logic [DATA_W-1:0] r_dataMem [NUM_EXP];
  logic              w_wrOk;
  logic              w_rdOk;

  assign w_wrOk = wrEn && (32'(wrIdx) < 32'(NUM_EXP));
  // The pointer runs one past the last entry after a pass; read zero there.
  assign w_rdOk = (32'(rdIdx) < 32'(NUM_EXP));

  always_ff @(posedge clk) begin
    if (w_wrOk) begin
      r_addrMem[wrIdx] <= wrAddr;
      r_dataMem[wrIdx] <= wrData;
    end
  end

  assign rdAddr = w_rdOk ? r_addrMem[rdIdx[IDX_W-1:0]] : '0;
  assign rdData = w_rdOk ? r_dataMem[rdIdx[IDX_W-1:0]] : '0;

endmodule

`default_nettype wire

// File: rtl/mem_write_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_write_checker : ordered expected-write monitor for the data-memory bus |
// | Optional: MWC_FAIL_CAPTURE_EN adds fail_addr / fail_data capture ports     |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int NUM_EXP      = 8,
  parameter int SCRATCH_BASE = 96,
  parameter int SCRATCH_SIZE = 4,
  parameter int TIMEOUT      = 1000,
  localparam int IDX_W       = idxWidth(NUM_EXP),
  localparam int PTR_W       = IDX_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] data_adr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [PTR_W-1:0]  num_exp,
  input  logic              start,
  input  logic              clear,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [PTR_W-1:0]  match_cnt,
  output logic [31:0]       cycle_cnt
`ifdef MWC_FAIL_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
`endif
);

  localparam logic [ADDR_W:0]  c_scratchLo  = (ADDR_W+1)'(SCRATCH_BASE);
  localparam logic [ADDR_W:0]  c_scratchHi  = (ADDR_W+1)'(SCRATCH_BASE) + (ADDR_W+1)'(SCRATCH_SIZE);
  localparam bit               c_scratchEn  = (SCRATCH_SIZE != 0);
  localparam bit               c_timeoutEn  = (TIMEOUT != 0);
  localparam logic [31:0]      c_timeoutEnd = c_timeoutEn ? 32'(TIMEOUT - 1) : 32'd0;
  localparam logic [PTR_W-1:0] c_numExpMax  = PTR_W'(NUM_EXP);

  state_t            r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_numExp;
  logic              r_done;
  logic              r_pass;
  logic              r_fail;
  logic [1:0]        r_failCode;
  logic [31:0]       r_cycleCnt;

  logic [ADDR_W-1:0] w_expAddr;
  logic [DATA_W-1:0] w_expData;
  logic              w_hit;
  logic              w_last;
  logic              w_inScratch;
  logic              w_timeout;
  logic              w_cfgOk;
  logic              w_goFailUnexp;
  logic              w_goFailTimeout;
  logic              w_goFailCfg;
  logic [31:0]       w_cycleNext;

  mwc_exp_table #(
    .NUM_EXP (NUM_EXP),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W),
    .PTR_W   (PTR_W)
  ) u_table (
    .clk    (clk),
    .wrEn   (exp_we && (r_state == ST_IDLE)),
    .wrIdx  (exp_idx),
    .wrAddr (exp_addr),
    .wrData (exp_data),
    .rdIdx  (r_ptr),
    .rdAddr (w_expAddr),
    .rdData (w_expData)
  );

  assign w_hit       = (data_adr == w_expAddr) && (write_data == w_expData);
  assign w_last      = (r_ptr == r_numExp - PTR_W'(1));
  assign w_inScratch = c_scratchEn && ({1'b0, data_adr} >= c_scratchLo) && ({1'b0, data_adr} < c_scratchHi);
  // >= rather than == so a scratch write on the deadline cycle cannot dodge the timeout.
  assign w_timeout   = c_timeoutEn && (r_cycleCnt >= c_timeoutEnd);
  assign w_cfgOk     = (num_exp != '0) && (num_exp <= c_numExpMax);
  assign w_cycleNext = (&r_cycleCnt) ? r_cycleCnt : r_cycleCnt + 32'd1;

  assign w_goFailUnexp   = (r_state == ST_ARMED) && mem_write && !w_hit && !w_inScratch;
  assign w_goFailTimeout = (r_state == ST_ARMED) && !mem_write && w_timeout;
  assign w_goFailCfg     = (r_state == ST_IDLE) && start && !w_cfgOk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_numExp   <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_failCode <= FC_NONE;
      r_cycleCnt <= '0;
    end else if (clear) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_failCode <= FC_NONE;
      r_cycleCnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && w_cfgOk) begin
            r_state    <= ST_ARMED;
            r_numExp   <= num_exp;
            r_ptr      <= '0;
            r_cycleCnt <= '0;
          end else if (w_goFailCfg) begin
            r_state    <= ST_FAIL;
            r_done     <= 1'b1;
            r_fail     <= 1'b1;
            r_failCode <= FC_CFG;
          end
        end
        ST_ARMED: begin
          // The decisive edge leaves cycle_cnt at the value that triggered it.
          if (mem_write && w_hit) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (w_last) begin
              r_state <= ST_PASS;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_cycleCnt <= w_cycleNext;
            end
          end else if (w_goFailUnexp || w_goFailTimeout) begin
            r_state    <= ST_FAIL;
            r_done     <= 1'b1;
            r_fail     <= 1'b1;
            r_failCode <= w_goFailUnexp ? FC_UNEXP : FC_TIMEOUT;
          end else begin
            r_cycleCnt <= w_cycleNext;
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign fail_code = r_failCode;
  assign match_cnt = r_ptr;
  assign cycle_cnt = r_cycleCnt;

`ifdef MWC_FAIL_CAPTURE_EN
  logic [ADDR_W-1:0] r_failAddr;
  logic [DATA_W-1:0] r_failData;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_failAddr <= '0;
      r_failData <= '0;
    end else if (clear) begin
      r_failAddr <= '0;
      r_failData <= '0;
    end else if (w_goFailUnexp) begin
      r_failAddr <= data_adr;
      r_failData <= write_data;
    end else if (w_goFailTimeout || w_goFailCfg) begin
      r_failAddr <= w_expAddr;
      r_failData <= w_expData;
    end
  end

  assign fail_addr = r_failAddr;
  assign fail_data = r_failData;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_write_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_write_checker : scoreboard bench for mem_write_checker (TIMEOUT=50) |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_mem_write_checker;
  import mwc_pkg::*;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        memWrite, expWe, start, clear;
  logic [31:0] dataAdr, writeData, expAddr, expData;
  logic [2:0]  expIdx;
  logic [3:0]  numExp;
  logic        done, pass, fail;
  logic [1:0]  failCode;
  logic [3:0]  matchCnt;
  logic [31:0] cycleCnt;
`ifdef MWC_FAIL_CAPTURE_EN
  logic [31:0] failAddr, failData;
`endif

  always #5 clk = ~clk;

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .NUM_EXP(8),
    .SCRATCH_BASE(96), .SCRATCH_SIZE(4), .TIMEOUT(50)
  ) dut (
    .clk(clk), .reset(rstN), .mem_write(memWrite), .data_adr(dataAdr),
    .write_data(writeData), .exp_we(expWe), .exp_idx(expIdx),
    .exp_addr(expAddr), .exp_data(expData), .num_exp(numExp),
    .start(start), .clear(clear), .done(done), .pass(pass), .fail(fail),
    .fail_code(failCode), .match_cnt(matchCnt), .cycle_cnt(cycleCnt)
`ifdef MWC_FAIL_CAPTURE_EN
    , .fail_addr(failAddr), .fail_data(failData)
`endif
  );

  typedef struct {
    logic        ps;
    logic        fl;
    logic [1:0]  code;
    logic [3:0]  mc;
    logic [31:0] cc;
    logic [31:0] fa;
    logic [31:0] fd;
  } verdict_t;

  verdict_t sbQ[$];
  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act === req) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic expectVerdict(input logic ps, input logic fl, input logic [1:0] code,
                               input logic [3:0] mc, input logic [31:0] cc,
                               input logic [31:0] fa, input logic [31:0] fd);
    verdict_t v;
    v.ps = ps; v.fl = fl; v.code = code; v.mc = mc; v.cc = cc; v.fa = fa; v.fd = fd;
    sbQ.push_back(v);
  endtask

  // One call = one clock cycle of stimulus, applied on the falling edge.
  task automatic drive(input logic we, input logic [2:0] idx, input logic [31:0] ea,
                       input logic [31:0] ed, input logic st, input logic [3:0] ne,
                       input logic clr, input logic mw, input logic [31:0] adr,
                       input logic [31:0] wd);
    @(negedge clk);
    expWe = we; expIdx = idx; expAddr = ea; expData = ed;
    start = st; numExp = ne; clear = clr;
    memWrite = mw; dataAdr = adr; writeData = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d);
    drive(1, idx, a, d, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic startRun(input logic [3:0] ne);
    drive(0, 0, 0, 0, 1, ne, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(0, 0, 0, 0, 0, 0, 0, 1, a, d);
  endtask

  task automatic checkZero(input string name);
    check(name, 64'({done, pass, fail, failCode, matchCnt, cycleCnt}), 64'd0);
`ifdef MWC_FAIL_CAPTURE_EN
    check({name, "_capture"}, {failAddr, failData}, 64'd0);
`endif
  endtask

  task automatic clearRun(input string name);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
    @(posedge clk); #1;
    checkZero(name);
  endtask

  // Monitor: every rising edge of done consumes one expected verdict.
  initial begin
    logic     prevDone;
    verdict_t e;
    prevDone = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (done === 1'b1 && prevDone !== 1'b1) begin
        if (sbQ.size() == 0) begin
          check("unexpected_verdict", 64'(done), 64'd0);
        end else begin
          e = sbQ.pop_front();
          check("pass", 64'(pass), 64'(e.ps));
          check("fail", 64'(fail), 64'(e.fl));
          check("fail_code", 64'(failCode), 64'(e.code));
          check("match_cnt", 64'(matchCnt), 64'(e.mc));
          check("cycle_cnt", 64'(cycleCnt), 64'(e.cc));
          check("pass_fail_excl", 64'(pass & fail), 64'd0);
`ifdef MWC_FAIL_CAPTURE_EN
          check("fail_addr", 64'(failAddr), 64'(e.fa));
          check("fail_data", 64'(failData), 64'(e.fd));
`endif
        end
      end
      prevDone = done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d verdicts pending", sbQ.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    memWrite = 0; dataAdr = 0; writeData = 0; expWe = 0; expIdx = 0;
    expAddr = 0; expData = 0; numExp = 0; start = 0; clear = 0;
    #1 rstN = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    checkZero("reset");
    @(negedge clk);
    rstN = 1'b1;

    // Single entry; scratch write is tolerated, then the expected write passes.
    load(0, 100, 7);
    expectVerdict(1, 0, FC_NONE, 1, 1, 0, 0);
    startRun(1); wr(96, 3); wr(100, 7); idle(2);
    clearRun("clear_after_pass");

    // Wrong address.
    expectVerdict(0, 1, FC_UNEXP, 0, 0, 104, 7);
    startRun(1); wr(104, 7); idle(2);
    clearRun("clear_after_bad_addr");

    // Right address, wrong data.
    expectVerdict(0, 1, FC_UNEXP, 0, 0, 100, 8);
    startRun(1); wr(100, 8); idle(2);
    clearRun("clear_after_bad_data");

    // Scratch window edges: 99 is the last tolerated byte, 95 sits just below.
    expectVerdict(0, 1, FC_UNEXP, 0, 1, 95, 1);
    startRun(1); wr(99, 1); wr(95, 1); idle(2);
    clearRun("clear_after_scratch_edge");

    // Two entries in order.
    load(1, 104, 9);
    expectVerdict(1, 0, FC_NONE, 2, 1, 0, 0);
    startRun(2); wr(100, 7); wr(104, 9); idle(2);
    clearRun("clear_after_two_pass");

    // Two entries reversed.
    expectVerdict(0, 1, FC_UNEXP, 0, 0, 104, 9);
    startRun(2); wr(104, 9); wr(100, 7); idle(2);
    clearRun("clear_after_reverse");

    // Timeout with no writes: fires when cycle_cnt reaches 49.
    expectVerdict(0, 1, FC_TIMEOUT, 0, 49, 100, 7);
    startRun(1); idle(55);
    clearRun("clear_after_timeout");

    // Final match lands on the timeout cycle: pass wins.
    expectVerdict(1, 0, FC_NONE, 1, 49, 0, 0);
    startRun(1); idle(49); wr(100, 7); idle(2);
    clearRun("clear_after_late_pass");

    // Bad configurations.
    expectVerdict(0, 1, FC_CFG, 0, 0, 100, 7);
    startRun(0); idle(2);
    clearRun("clear_after_cfg0");
    expectVerdict(0, 1, FC_CFG, 0, 0, 100, 7);
    startRun(9); idle(2);
    clearRun("clear_after_cfg9");

    // Reset mid-run, then rerun against the retained table.
    startRun(2); wr(100, 7);
    @(posedge clk); #1;
    check("midrun_match_cnt", 64'(matchCnt), 64'd1);
    @(negedge clk);
    memWrite = 1'b0;
    rstN = 1'b0;
    #1;
    checkZero("async_reset_midrun");
    @(negedge clk);
    rstN = 1'b1;
    expectVerdict(1, 0, FC_NONE, 2, 1, 0, 0);
    startRun(2); wr(100, 7); wr(104, 9); idle(2);

    // Clear and start together from PASS: clear wins and the checker stays idle.
    drive(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    idle(3);
    @(posedge clk); #1;
    checkZero("clear_start_same_cycle");

    idle(3);
    check("scoreboard_drained", 64'(sbQ.size()), 64'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
